regfile_write_arbiter: RTL

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter.sv | 100 ++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Register-file write port arbiter: round-robin between ALU (A) and load (B) writeback,
// with a 32-cycle zeroing sweep (CLEAR) on reset or on request.
//
// state   | meaning
// S_CLEAR | sweeping zero writes over x0..x31, requesters stalled, busy_o high
// S_RUN   | arbitrating A/B writebacks, one registered write per cycle
module regfile_write_arbiter #(
  parameter int DATA_W         = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              a_valid_i,
  input  logic [4:0]        a_rd_i,
  input  logic [DATA_W-1:0] a_data_i,
  output logic              a_ready_o,
  input  logic              b_valid_i,
  input  logic [4:0]        b_rd_i,
  input  logic [DATA_W-1:0] b_data_i,
  output logic              b_ready_o,
  output logic              wren_o,
  output logic [4:0]        rd_o,
  output logic [DATA_W-1:0] datard_o,
  output logic              busy_o
);

  localparam logic [0:0] S_CLEAR   = 1'b0;
  localparam logic [0:0] S_RUN     = 1'b1;
  localparam logic [0:0] RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;

  logic [0:0]        state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              prio_b_q, prio_b_d;   // 1: B wins a tie
  logic              wren_q, wren_d;
  logic [4:0]        rd_q, rd_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic run_ok, gnt_a, gnt_b;

  assign run_ok = (state_q == S_RUN) && !clear_i;
  assign gnt_a  = run_ok && a_valid_i && (!b_valid_i || !prio_b_q);
  assign gnt_b  = run_ok && b_valid_i && (!a_valid_i ||  prio_b_q);

  assign a_ready_o = gnt_a;
  assign b_ready_o = gnt_b;
  assign busy_o    = (state_q == S_CLEAR);
  assign wren_o    = wren_q;
  assign rd_o      = rd_q;
  assign datard_o  = data_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prio_b_d = prio_b_q;
    wren_d   = 1'b0;
    rd_d     = rd_q;
    data_d   = data_q;
    if (state_q == S_CLEAR) begin
      wren_d = 1'b1;
      rd_d   = cnt_q;
      data_d = '0;
      cnt_d  = cnt_q + 5'd1;
      if (cnt_q == 5'd31) state_d = S_RUN;
    end else if (clear_i) begin
      state_d = S_CLEAR;
      cnt_d   = 5'd0;
    end else if (gnt_a) begin
      // x0 is hardwired zero: accept the transfer but suppress the write
      wren_d   = (a_rd_i != 5'd0);
      rd_d     = a_rd_i;
      data_d   = a_data_i;
      prio_b_d = 1'b1;
    end else if (gnt_b) begin
      wren_d   = (b_rd_i != 5'd0);
      rd_d     = b_rd_i;
      data_d   = b_data_i;
      prio_b_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= RST_STATE;
      cnt_q    <= 5'd0;
      prio_b_q <= 1'b0;
      wren_q   <= 1'b0;
      rd_q     <= 5'd0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prio_b_q <= prio_b_d;
      wren_q   <= wren_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
    end
  end

endmodule
